// File: rtl/axis_crc_pkg.sv
// Shared CRC32/MPEG-2 definitions for the AXI-Stream CRC generator and checker.
// Word-wide, MSB-first update with no reflection and no final XOR.
`timescale 1ns/1ps
package axis_crc_pkg;

    localparam logic [31:0] CRC32_MPEG2_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_MPEG2_INIT = 32'hFFFF_FFFF;

    // Advances the CRC register over one 32-bit word, most significant bit first.
    function automatic logic [31:0] crc32_mpeg2_word(
        input logic [31:0] crc,
        input logic [31:0] data,
        input logic [31:0] poly = CRC32_MPEG2_POLY
    );
        logic [31:0] c;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ poly;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/axis_crc32_mpeg2_checker.sv
// Checks the trailing CRC32/MPEG-2 word of each AXI-Stream packet, strips it, and
// moves tlast onto the last payload word; reports pass/fail and a saturating error count.
`timescale 1ns/1ps
module axis_crc32_mpeg2_checker
    import axis_crc_pkg::*;
#(
    parameter int unsigned  AXI_DATA_WIDTH = 32,
    parameter logic [31:0]  POLY_CRC       = CRC32_MPEG2_POLY,
    parameter logic [31:0]  INIT_CRC       = CRC32_MPEG2_INIT,
    parameter int unsigned  ERR_CNT_WIDTH  = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic                      crc_done,
    output logic                      crc_ok,
    output logic [ERR_CNT_WIDTH-1:0]  crc_err_cnt
);

    logic [31:0]               crc_q, crc_d;
    logic [AXI_DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                      hold_valid_q, hold_valid_d;
    logic [AXI_DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                      m_tvalid_q, m_tvalid_d;
    logic                      m_tlast_q, m_tlast_d;
    logic                      done_q, done_d;
    logic                      ok_q, ok_d;
    logic [ERR_CNT_WIDTH-1:0]  err_q, err_d;

    logic        accept;
    logic [31:0] crc_next;
    logic        residue_zero;

    // The holdback stage keeps one word back so tlast can be moved onto it when the CRC word arrives.
    assign s_axis_tready = !hold_valid_q || !m_tvalid_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign crc_next      = crc32_mpeg2_word(crc_q, s_axis_tdata, POLY_CRC);
    assign residue_zero  = (crc_next == 32'h0);

    always_comb begin
        crc_d        = crc_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        m_tlast_d    = m_tlast_q;
        done_d       = 1'b0;
        ok_d         = ok_q;
        err_d        = err_q;

        if (m_tvalid_q && m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end

        if (accept) begin
            if (hold_valid_q) begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = hold_data_q;
                m_tlast_d  = s_axis_tlast;
            end

            if (s_axis_tlast) begin
                // CRC word: never forwarded; restart the CRC so the next packet can follow immediately.
                hold_valid_d = 1'b0;
                crc_d        = INIT_CRC;
                done_d       = 1'b1;
                ok_d         = residue_zero;
                if (!residue_zero && (err_q != '1)) begin
                    err_d = err_q + ERR_CNT_WIDTH'(1);
                end
            end else begin
                hold_valid_d = 1'b1;
                hold_data_d  = s_axis_tdata;
                crc_d        = crc_next;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            crc_q        <= INIT_CRC;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            done_q       <= 1'b0;
            ok_q         <= 1'b0;
            err_q        <= '0;
        end else begin
            crc_q        <= crc_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            done_q       <= done_d;
            ok_q         <= ok_d;
            err_q        <= err_d;
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign crc_done      = done_q;
    assign crc_ok        = ok_q;
    assign crc_err_cnt   = err_q;

endmodule

// File: tb/tb_axis_crc32_mpeg2_checker.sv
// Randomised self-checking bench for the CRC32/MPEG-2 stream checker, with a
// bit-serial long-division reference and scoreboards for payload beats and check results.
`timescale 1ns/1ps
module tb_axis_crc32_mpeg2_checker;

    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        crc_done;
    logic        crc_ok;
    logic [15:0] crc_err_cnt;

    logic        s_axis_tready2;
    logic [31:0] m_axis_tdata2;
    logic        m_axis_tvalid2;
    logic        m_axis_tlast2;
    logic        crc_done2;
    logic        crc_ok2;
    logic [1:0]  crc_err_cnt2;

    always #5 aclk = ~aclk;

    axis_crc32_mpeg2_checker u_dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .crc_done      (crc_done),
        .crc_ok        (crc_ok),
        .crc_err_cnt   (crc_err_cnt)
    );

    // Narrow-counter copy sharing all inputs, used to observe saturation.
    axis_crc32_mpeg2_checker #(.ERR_CNT_WIDTH(2)) u_sat (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready2),
        .m_axis_tdata  (m_axis_tdata2),
        .m_axis_tvalid (m_axis_tvalid2),
        .m_axis_tlast  (m_axis_tlast2),
        .m_axis_tready (m_axis_tready),
        .crc_done      (crc_done2),
        .crc_ok        (crc_ok2),
        .crc_err_cnt   (crc_err_cnt2)
    );

    typedef struct { logic [31:0] data; logic last; } beat_t;
    typedef struct { logic ok; int err; } res_t;

    int          checks = 0;
    int          failures = 0;
    beat_t       exp_out[$];
    res_t        exp_res[$];
    int          model_err = 0;
    int          done_count = 0;
    int          rdy_mode = 0;
    int          pat_idx = 0;
    logic [3:0]  rdy_pat = 4'b1001;
    logic [31:0] pkt[$];

    // CRC by polynomial long division of the augmented message; the init value is
    // equivalent to inverting the first 32 bits of the augmented bit stream.
    function automatic logic [31:0] ref_crc(input logic [31:0] w[$]);
        bit          bits[$];
        logic [31:0] r;
        bit          top;
        r = '0;
        foreach (w[k]) for (int i = 31; i >= 0; i--) bits.push_back(w[k][i]);
        for (int i = 0; i < 32; i++) bits.push_back(1'b0);
        for (int i = 0; i < 32; i++) bits[i] = ~bits[i];
        foreach (bits[k]) begin
            top = r[31];
            r = {r[30:0], bits[k]};
            if (top) r = r ^ POLY;
        end
        return r;
    endfunction

    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            2: begin m_axis_tready = rdy_pat[pat_idx % 4]; pat_idx++; end
            default: m_axis_tready = 1'b0;
        endcase
    end

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge aclk) begin
        beat_t b;
        res_t  r;
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            checks++;
            if ({s_axis_tready2, m_axis_tvalid2, m_axis_tdata2, m_axis_tlast2, crc_done2, crc_ok2} !==
                {s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, crc_done, crc_ok}) begin
                failures++;
                $display("FAIL twin_match: narrow copy valid=%b data=%h done=%b, wide copy valid=%b data=%h done=%b",
                         m_axis_tvalid2, m_axis_tdata2, crc_done2, m_axis_tvalid, m_axis_tdata, crc_done);
            end
            if (prev_stall) begin
                checks++;
                if (!(m_axis_tvalid === 1'b1 && m_axis_tdata === prev_data && m_axis_tlast === prev_last)) begin
                    failures++;
                    $display("FAIL out_hold: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (s_axis_tready !== 1'b1) begin
                checks++;
                if (!(m_axis_tvalid === 1'b1 && m_axis_tready === 1'b0)) begin
                    failures++;
                    $display("FAIL tready_low: s_tready=%b with m_tvalid=%b m_tready=%b", s_axis_tready,
                             m_axis_tvalid, m_axis_tready);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_out.size() == 0) begin
                    failures++;
                    $display("FAIL out_beat: unexpected beat data=%h last=%b, none required", m_axis_tdata, m_axis_tlast);
                end else begin
                    b = exp_out.pop_front();
                    if (m_axis_tdata !== b.data || m_axis_tlast !== b.last) begin
                        failures++;
                        $display("FAIL out_beat: got data=%h last=%b, need data=%h last=%b",
                                 m_axis_tdata, m_axis_tlast, b.data, b.last);
                    end else begin
                        $display("beat data=%h last=%b", m_axis_tdata, m_axis_tlast);
                    end
                end
            end
            if (crc_done) begin
                done_count++;
                checks++;
                if (exp_res.size() == 0) begin
                    failures++;
                    $display("FAIL crc_done: unexpected pulse ok=%b, no packet pending", crc_ok);
                end else begin
                    r = exp_res.pop_front();
                    if (crc_ok !== r.ok || crc_err_cnt !== 16'(r.err) ||
                        crc_err_cnt2 !== 2'((r.err > 3) ? 3 : r.err)) begin
                        failures++;
                        $display("FAIL crc_result: got ok=%b err=%0d err2=%0d, need ok=%b err=%0d err2=%0d",
                                 crc_ok, crc_err_cnt, crc_err_cnt2, r.ok, r.err, (r.err > 3) ? 3 : r.err);
                    end else begin
                        $display("packet done ok=%b err=%0d err2=%0d", crc_ok, crc_err_cnt, crc_err_cnt2);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #2;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        bit acc;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        n = 0;
        acc = 0;
        while (!acc && n < 200) begin
            @(negedge aclk);
            acc = s_axis_tready;
            @(posedge aclk);
            #2;
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_beat: timeout, tready=0 for %0d cycles, required 1", n);
        end
    endtask

    // Sends pkt plus its CRC word, optionally flipping one bit of word cw, and queues the expectations.
    task automatic send_packet(input int cw, input int cb, input bit gaps, input bit keep);
        logic [31:0] full[$];
        logic [31:0] pay[$];
        logic [31:0] t;
        res_t        r;
        full = pkt;
        full.push_back(ref_crc(pkt));
        if (cw >= 0) begin
            t = full[cw];
            t[cb] = ~t[cb];
            full[cw] = t;
        end
        for (int i = 0; i < full.size() - 1; i++) pay.push_back(full[i]);
        r.ok = (ref_crc(pay) == full[full.size() - 1]);
        if (!r.ok && model_err < 65535) model_err++;
        r.err = model_err;
        foreach (pay[i]) exp_out.push_back('{data: pay[i], last: (i == pay.size() - 1)});
        exp_res.push_back(r);
        foreach (full[i]) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_axis_tvalid = 1'b0;
                idle($urandom_range(1, 2));
            end
            send_beat(full[i], i == full.size() - 1);
        end
        if (!keep) s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_out.size() != 0 || exp_res.size() != 0) && n < 300) begin
            @(posedge aclk);
            n++;
        end
        idle(3);
        checks++;
        if (exp_out.size() != 0 || exp_res.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d beats and %0d results outstanding, need 0", name, exp_out.size(), exp_res.size());
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tdata = '0;
        m_axis_tready = 1'b1;
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, crc_done, crc_ok, crc_err_cnt, s_axis_tready} !== {36'h0, 16'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: got valid=%b last=%b data=%h done=%b ok=%b err=%0d rdy=%b, need zeros and rdy=1",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, crc_done, crc_ok, crc_err_cnt, s_axis_tready);
        end
        idle(3);
        areset = 1'b0;
        idle(2);
    endtask

    task automatic test_known_packet();
        int d0;
        rdy_mode = 0;
        d0 = done_count;
        pkt = '{32'h3132_3334, 32'h3536_3738};
        send_packet(-1, 0, 0, 0);
        drain("known");
        checks++;
        if (done_count - d0 != 1 || crc_ok !== 1'b1 || crc_err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL known_packet: got dones=%0d ok=%b err=%0d, need dones=1 ok=1 err=0", done_count - d0, crc_ok, crc_err_cnt);
        end
    endtask

    task automatic test_corrupt();
        pkt = '{32'h3132_3334, 32'h3536_3738};
        send_packet(1, 0, 0, 0);
        drain("corrupt");
        checks++;
        if (crc_ok !== 1'b0 || crc_err_cnt !== 16'd1) begin
            failures++;
            $display("FAIL corrupt_packet: got ok=%b err=%0d, need ok=0 err=1", crc_ok, crc_err_cnt);
        end
    endtask

    task automatic test_crc_only();
        int d0;
        d0 = done_count;
        pkt = {};
        send_packet(-1, 0, 0, 0);
        drain("crc_only");
        checks++;
        if (done_count - d0 != 1 || crc_ok !== 1'b1) begin
            failures++;
            $display("FAIL crc_only: got dones=%0d ok=%b, need dones=1 ok=1", done_count - d0, crc_ok);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        rdy_mode = 2;
        d0 = done_count;
        for (int p = 0; p < 2; p++) begin
            pkt = {};
            for (int i = 0; i < 4; i++) pkt.push_back($urandom);
            send_packet(-1, 0, 0, p == 0);
        end
        drain("b2b");
        checks++;
        if (done_count - d0 != 2) begin
            failures++;
            $display("FAIL back_to_back: got dones=%0d, need 2", done_count - d0);
        end
        rdy_mode = 0;
    endtask

    task automatic test_abort();
        int d0;
        rdy_mode = 3;
        idle(1);
        d0 = done_count;
        send_beat($urandom, 1'b0);
        send_beat($urandom, 1'b0);
        s_axis_tvalid = 1'b0;
        idle(1);
        areset = 1'b1;
        #1;
        checks++;
        if ({m_axis_tvalid, crc_done, crc_ok, crc_err_cnt} !== 19'h0) begin
            failures++;
            $display("FAIL abort_reset: got valid=%b done=%b ok=%b err=%0d, need all 0", m_axis_tvalid, crc_done, crc_ok, crc_err_cnt);
        end
        exp_out.delete();
        exp_res.delete();
        model_err = 0;
        idle(2);
        areset = 1'b0;
        rdy_mode = 0;
        idle(3);
        checks++;
        if (m_axis_tvalid !== 1'b0 || done_count != d0) begin
            failures++;
            $display("FAIL abort_discard: got valid=%b dones=%0d, need valid=0 dones=0", m_axis_tvalid, done_count - d0);
        end
        pkt = {};
        for (int i = 0; i < 3; i++) pkt.push_back($urandom);
        send_packet(-1, 0, 0, 0);
        drain("abort_clean");
        checks++;
        if (done_count - d0 != 1 || crc_ok !== 1'b1) begin
            failures++;
            $display("FAIL abort_clean: got dones=%0d ok=%b, need dones=1 ok=1", done_count - d0, crc_ok);
        end
    endtask

    task automatic test_saturation();
        rdy_mode = 1;
        for (int p = 0; p < 5; p++) begin
            pkt = '{$urandom, $urandom};
            send_packet($urandom_range(0, 2), $urandom_range(0, 31), 0, 1);
        end
        s_axis_tvalid = 1'b0;
        drain("sat");
        checks++;
        if (crc_err_cnt2 !== 2'd3 || crc_err_cnt !== 16'(model_err)) begin
            failures++;
            $display("FAIL saturation: got err2=%0d err=%0d, need err2=3 err=%0d", crc_err_cnt2, crc_err_cnt, model_err);
        end
    endtask

    task automatic test_random();
        int d0;
        int len;
        d0 = done_count;
        for (int p = 0; p < 25; p++) begin
            rdy_mode = $urandom_range(0, 2);
            len = $urandom_range(0, 6);
            pkt = {};
            for (int i = 0; i < len; i++) pkt.push_back($urandom);
            if ($urandom_range(0, 9) < 3) send_packet($urandom_range(0, len), $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else send_packet(-1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        s_axis_tvalid = 1'b0;
        drain("random");
        checks++;
        if (done_count - d0 != 25 || crc_err_cnt !== 16'(model_err)) begin
            failures++;
            $display("FAIL random: got dones=%0d err=%0d, need dones=25 err=%0d", done_count - d0, crc_err_cnt, model_err);
        end
    endtask

    initial begin
        test_reset();
        test_known_packet();
        test_corrupt();
        test_crc_only();
        test_back_to_back();
        test_abort();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
